// File: rtl/writeback_queue_if.sv
// Bus bundle for writeback_queue: producer handshake, register-file write
// port, occupancy and the decode-side lookup probe.
// The master modport is the producer/decode/register-file side; the slave
// modport is the queue itself.
interface writeback_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [4:0]      in_reg;
    logic [63:0]     in_data;
    logic            in_ready;
    logic            hold;
    logic            regwrite;
    logic [4:0]      writeReg;
    logic [63:0]     writeData;
    logic [CW-1:0]   count;
    logic [4:0]      lookup_reg;
    logic            lookup_hit;
    logic [63:0]     lookup_data;

    modport master (
        output in_valid, in_reg, in_data, hold, lookup_reg,
        input  in_ready, regwrite, writeReg, writeData, count,
               lookup_hit, lookup_data
    );

    modport slave (
        input  in_valid, in_reg, in_data, hold, lookup_reg,
        output in_ready, regwrite, writeReg, writeData, count,
               lookup_hit, lookup_data
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO of pending register-file writebacks.
// Writes to XZR (register 31) are accepted and dropped. The head entry is
// written to the register file whenever the queue is non-empty and hold is low.
// Optional feature: define WBQ_FORWARD_EN to enable the lookup port, which
// forwards the data of the youngest pending entry targeting lookup_reg.
// Without it lookup_hit/lookup_data are tied to 0.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] XZR = 5'd31;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic [4:0]  reg_mem  [DEPTH];
    logic [63:0] data_mem [DEPTH];

    logic not_empty;
    logic full;
    logic enq;
    logic ret;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign enq       = bus.in_valid && !full && (bus.in_reg != XZR);
    assign ret       = not_empty && !bus.hold;

    assign bus.in_ready  = !full;
    assign bus.regwrite  = ret;
    assign bus.writeReg  = not_empty ? reg_mem[head]  : 5'd0;
    assign bus.writeData = not_empty ? data_mem[head] : 64'd0;
    assign bus.count     = count_q;

    // Head/tail pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (ret) begin
                head <= head + PW'(1);
            end
            case ({enq, ret})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            reg_mem[tail]  <= bus.in_reg;
            data_mem[tail] <= bus.in_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic        hit_c;
    logic [63:0] data_c;

    // Scan live entries oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_c  = 1'b0;
        data_c = 64'd0;
        if (bus.lookup_reg != XZR) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (reg_mem[head + PW'(i)] == bus.lookup_reg)) begin
                    hit_c  = 1'b1;
                    data_c = data_mem[head + PW'(i)];
                end
            end
        end
    end

    assign bus.lookup_hit  = hit_c;
    assign bus.lookup_data = data_c;
`else
    logic unused_lookup;

    assign unused_lookup   = ^bus.lookup_reg;
    assign bus.lookup_hit  = 1'b0;
    assign bus.lookup_data = 64'd0;
`endif

endmodule
